scs8hd_muxsel_seq: RTL and testbench

SCS8HD_MUXSEL_SEQ -- requirements
Module: scs8hd_muxsel_seq

---
 rtl/scs8hd_muxsel_seq.sv | 137 +++++++++++++
 tb/tb_scs8hd_muxsel_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_muxsel_seq.sv
// ---------------------------------------------------------------------------
// scs8hd_muxsel_seq
//
// Select sequencer for downstream scs8hd mux2 cells. It owns the registered
// S pin of the muxes and tells the consumer when the mux output X has
// settled (x_valid). After every change of S, the output is blanked for
// SETTLE_CYC cycles. The new selection then dwells for HOLD_MIN qualified
// cycles before the next request can be accepted.
//
// Parameters
//   SETTLE_CYC  cycles x_valid stays low after an S change (1..15)
//   HOLD_MIN    qualified dwell cycles before the next accept (0..15)
//   CNT_W       width of the saturating switch counter
//
// Ports
//   clk         single clock, all state changes on the rising edge
//   reset       synchronous, active-high reset
//   req_valid   a select request is present
//   req_sel     requested select value (0 -> A0, 1 -> A1)
//   req_ready   request is accepted this cycle (handshake = valid & ready)
//   s           registered select, wired to the mux2 S pin
//   x_valid     mux output is settled and may be sampled
//   sw_cnt_clr  synchronous clear of sw_cnt
//   sw_cnt      number of accepted requests that changed s (saturating)
// ---------------------------------------------------------------------------
module scs8hd_muxsel_seq #(
  parameter int SETTLE_CYC = 2,
  parameter int HOLD_MIN   = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_sel,
  output logic             req_ready,
  output logic             s,
  output logic             x_valid,
  input  logic             sw_cnt_clr,
  output logic [CNT_W-1:0] sw_cnt
);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_DWELL  = 2'd1,
    ST_OPEN   = 2'd2
  } state_t;

  // The shared down-counter holds "remaining cycles minus one", so a phase
  // ends on the cycle the counter reads zero.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] HOLD_LOAD   = (HOLD_MIN == 0) ? 4'd0 : 4'(HOLD_MIN - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             s_q, s_d;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
  logic             handshake;
  logic             do_switch;

  // Handshakes only exist in OPEN; anything presented while busy is left
  // with the upstream, which keeps holding it.
  assign handshake = (state_q == ST_OPEN) && req_valid;
  assign do_switch = handshake && (req_sel != s_q);

  // Next-state logic: phase sequencing, select update and switch counting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    sw_cnt_d = sw_cnt_q;

    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          if (HOLD_MIN == 0) begin
            state_d = ST_OPEN;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_DWELL;
            cnt_d   = HOLD_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DWELL: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_OPEN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_OPEN: begin
        // A same-value request is simply consumed and OPEN is kept.
        if (do_switch) begin
          s_d     = req_sel;
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      default: begin
        state_d = ST_SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
    endcase

    // Clear beats a coincident increment; the count sticks at all ones.
    if (sw_cnt_clr) begin
      sw_cnt_d = '0;
    end else if (do_switch && (sw_cnt_q != {CNT_W{1'b1}})) begin
      sw_cnt_d = sw_cnt_q + CNT_W'(1);
    end
  end

  // State register. Reset wins over everything and reloads the settle
  // phase from scratch, discarding any partial count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_SETTLE;
      cnt_q    <= SETTLE_LOAD;
      s_q      <= 1'b0;
      sw_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      sw_cnt_q <= sw_cnt_d;
    end
  end

  // Outputs are pure decodes of registered state.
  assign s         = s_q;
  assign x_valid   = (state_q != ST_SETTLE);
  assign req_ready = (state_q == ST_OPEN);
  assign sw_cnt    = sw_cnt_q;

endmodule

// File: tb/tb_scs8hd_muxsel_seq.sv
// ---------------------------------------------------------------------------
// tb_scs8hd_muxsel_seq
//
// Directed bench for scs8hd_muxsel_seq with default parameters. Each test
// task queues the per-cycle outputs it expects ({s, x_valid, req_ready,
// sw_cnt}) when it plans its stimulus, then drives the inputs cycle by
// cycle and pops/compares one entry per cycle. Outputs are sampled and
// inputs are driven on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_scs8hd_muxsel_seq;

  localparam int SETTLE_CYC = 2;
  localparam int HOLD_MIN   = 4;
  localparam int CNT_W      = 8;

  typedef struct packed {
    logic             s;
    logic             xv;
    logic             rdy;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_sel;
  logic             req_ready;
  logic             s;
  logic             x_valid;
  logic             sw_cnt_clr;
  logic [CNT_W-1:0] sw_cnt;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  scs8hd_muxsel_seq #(
    .SETTLE_CYC(SETTLE_CYC),
    .HOLD_MIN  (HOLD_MIN),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .s         (s),
    .x_valid   (x_valid),
    .sw_cnt_clr(sw_cnt_clr),
    .sw_cnt    (sw_cnt)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Watchdog so a broken run still ends with a report.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push(input logic ps, input logic pxv, input logic prdy, input logic [CNT_W-1:0] pcnt);
    exp_t e;
    e.s   = ps;
    e.xv  = pxv;
    e.rdy = prdy;
    e.cnt = pcnt;
    sb.push_back(e);
  endtask

  // Expected outputs from the cycle after a switch (or reset) edge up to
  // and including the first OPEN cycle.
  task automatic push_timeline(input logic ps, input logic [CNT_W-1:0] pcnt);
    for (int i = 0; i < SETTLE_CYC; i++) push(ps, 1'b0, 1'b0, pcnt);
    for (int i = 0; i < HOLD_MIN; i++)   push(ps, 1'b1, 1'b0, pcnt);
    push(ps, 1'b1, 1'b1, pcnt);
  endtask

  task automatic test_reset();
    exp_t e;
    exp_t obs;
    int   k;
    // Hold reset over several edges with noise on the request inputs.
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; req_sel = 1'b1; sw_cnt_clr = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0; req_valid = 1'b0; req_sel = 1'b0; sw_cnt_clr = 1'b0;
    push_timeline(1'b0, 8'd0);
    k = 0;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = {s, x_valid, req_ready, sw_cnt};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL reset_release cyc=%0d: got s=%b xv=%b rdy=%b cnt=%0d, want s=%b xv=%b rdy=%b cnt=%0d",
                 k, obs.s, obs.xv, obs.rdy, obs.cnt, e.s, e.xv, e.rdy, e.cnt);
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t obs;
    int   k;
    // Three same-value requests on consecutive cycles, then idle.
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 1'b1, 8'd0);
    k = 0;
    while (sb.size() > 0) begin
      req_valid = (k < 3);
      req_sel   = 1'b0;
      e   = sb.pop_front();
      obs = {s, x_valid, req_ready, sw_cnt};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL back_to_back cyc=%0d: got s=%b xv=%b rdy=%b cnt=%0d, want s=%b xv=%b rdy=%b cnt=%0d",
                 k, obs.s, obs.xv, obs.rdy, obs.cnt, e.s, e.xv, e.rdy, e.cnt);
      end
      @(negedge clk);
      k++;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_switch();
    exp_t e;
    exp_t obs;
    int   k;
    push(1'b0, 1'b1, 1'b1, 8'd0);
    push_timeline(1'b1, 8'd1);
    k = 0;
    while (sb.size() > 0) begin
      req_valid = (k == 0);
      req_sel   = 1'b1;
      e   = sb.pop_front();
      obs = {s, x_valid, req_ready, sw_cnt};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL switch_to_1 cyc=%0d: got s=%b xv=%b rdy=%b cnt=%0d, want s=%b xv=%b rdy=%b cnt=%0d",
                 k, obs.s, obs.xv, obs.rdy, obs.cnt, e.s, e.xv, e.rdy, e.cnt);
      end
      @(negedge clk);
      k++;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_ignore_busy();
    exp_t e;
    exp_t obs;
    int   k;
    // Switch to 0, keep a toggling request up while busy, then the request
    // (sel=1) must be taken on the first OPEN cycle.
    push(1'b1, 1'b1, 1'b1, 8'd1);
    push_timeline(1'b0, 8'd2);
    push_timeline(1'b1, 8'd3);
    k = 0;
    while (sb.size() > 0) begin
      if (k == 0) begin
        req_valid = 1'b1; req_sel = 1'b0;
      end else if (k <= SETTLE_CYC + HOLD_MIN) begin
        req_valid = 1'b1; req_sel = k[0];
      end else if (k == SETTLE_CYC + HOLD_MIN + 1) begin
        req_valid = 1'b1; req_sel = 1'b1;
      end else begin
        req_valid = 1'b0; req_sel = 1'b0;
      end
      e   = sb.pop_front();
      obs = {s, x_valid, req_ready, sw_cnt};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL ignore_busy cyc=%0d: got s=%b xv=%b rdy=%b cnt=%0d, want s=%b xv=%b rdy=%b cnt=%0d",
                 k, obs.s, obs.xv, obs.rdy, obs.cnt, e.s, e.xv, e.rdy, e.cnt);
      end
      @(negedge clk);
      k++;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_saturate_clear();
    exp_t e;
    exp_t obs;
    int   k;
    logic exp_s;
    // Preload: 252 switches take the count from 3 to 255 and leave s=1.
    exp_s = 1'b1;
    for (int n = 0; n < 252; n++) begin
      req_valid = 1'b1;
      req_sel   = ~exp_s;
      exp_s     = ~exp_s;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (SETTLE_CYC + HOLD_MIN) @(negedge clk);
    end
    // A switch at 255 must stick; a switch with clear must zero the count.
    push(1'b1, 1'b1, 1'b1, 8'd255);
    push_timeline(1'b0, 8'd255);
    push_timeline(1'b1, 8'd0);
    k = 0;
    while (sb.size() > 0) begin
      if (k == 0) begin
        req_valid = 1'b1; req_sel = 1'b0; sw_cnt_clr = 1'b0;
      end else if (k == SETTLE_CYC + HOLD_MIN + 1) begin
        req_valid = 1'b1; req_sel = 1'b1; sw_cnt_clr = 1'b1;
      end else begin
        req_valid = 1'b0; sw_cnt_clr = 1'b0;
      end
      e   = sb.pop_front();
      obs = {s, x_valid, req_ready, sw_cnt};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL saturate_clear cyc=%0d: got s=%b xv=%b rdy=%b cnt=%0d, want s=%b xv=%b rdy=%b cnt=%0d",
                 k, obs.s, obs.xv, obs.rdy, obs.cnt, e.s, e.xv, e.rdy, e.cnt);
      end
      @(negedge clk);
      k++;
    end
    req_valid = 1'b0;
    sw_cnt_clr = 1'b0;
  endtask

  task automatic test_reset_dwell();
    exp_t e;
    exp_t obs;
    int   k;
    // Switch 1->0, then 0->1, then reset in the first DWELL cycle (s=1).
    push(1'b1, 1'b1, 1'b1, 8'd0);
    push_timeline(1'b0, 8'd1);
    for (int i = 0; i < SETTLE_CYC; i++) push(1'b1, 1'b0, 1'b0, 8'd2);
    push(1'b1, 1'b1, 1'b0, 8'd2);
    push_timeline(1'b0, 8'd0);
    k = 0;
    while (sb.size() > 0) begin
      reset = 1'b0;
      if (k == 0) begin
        req_valid = 1'b1; req_sel = 1'b0;
      end else if (k == SETTLE_CYC + HOLD_MIN + 1) begin
        req_valid = 1'b1; req_sel = 1'b1;
      end else if (k == SETTLE_CYC + HOLD_MIN + 1 + SETTLE_CYC + 1) begin
        reset = 1'b1; req_valid = 1'b1; req_sel = 1'b0;
      end else begin
        req_valid = 1'b0; req_sel = 1'b0;
      end
      e   = sb.pop_front();
      obs = {s, x_valid, req_ready, sw_cnt};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL reset_in_dwell cyc=%0d: got s=%b xv=%b rdy=%b cnt=%0d, want s=%b xv=%b rdy=%b cnt=%0d",
                 k, obs.s, obs.xv, obs.rdy, obs.cnt, e.s, e.xv, e.rdy, e.cnt);
      end
      @(negedge clk);
      k++;
    end
    reset = 1'b0;
    req_valid = 1'b0;
  endtask

  // Scenario sequence; each task starts and ends on a falling edge in OPEN.
  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_sel    = 1'b0;
    sw_cnt_clr = 1'b0;
    $display("[TB] starting scs8hd_muxsel_seq directed tests");
    test_reset();
    test_back_to_back();
    test_switch();
    test_ignore_busy();
    test_saturate_clear();
    test_reset_dwell();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
